pfb_input_sequencer: RTL and testbench
======================================

Name: pfb_input_sequencer

Overview:
- Transmit-side feeder for the M-channel PFB sample port.
- Takes a raw complex sample stream and tags each sample with its commutator phase, the active phase count and a frame-end tlast, so the PFB arms are loaded in order.
- Phases count down from num_phases-1 to 0; tlast is asserted on phase 0, which is where the PFB advances its offset counter.
- Includes a 2-entry skid buffer so that s_axis_tready is a registered signal and the downstream almost_full backpressure is absorbed without data loss.

Parameters:
- DATA_WIDTH, 32, sample width ({I[15:0], Q[15:0]}).
- PHASE_WIDTH, 3, phase index width; maximum phase count is 2**PHASE_WIDTH.
- NPH_WIDTH, 4, width of the phase-count fields; equals PHASE_WIDTH+1.

Ports:
- clk  in  1  clock.
- sync_reset_n  in  1  reset; one clock domain, reset is synchronous and active-low.
- cfg_num_phases  in  NPH_WIDTH  requested phase count; legal range 2..2**PHASE_WIDTH.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tdata  in  DATA_WIDTH  input sample.
- s_axis_tready  out  1  registered ready.
- m_axis_tvalid  out  1  output valid, driven to the PFB s_axis_tvalid.
- m_axis_tdata  out  DATA_WIDTH  sample.
- m_axis_tlast  out  1  high on phase 0, the last sample of a frame.
- m_axis_tready  in  1  downstream ready, i.e. the PFB s_axis_tready.
- phase  out  PHASE_WIDTH  phase of the current m_axis word.
- num_phases  out  NPH_WIDTH  active phase count for the current m_axis word.
- cfg_err  out  1  sticky flag; set when an illegal cfg_num_phases is sampled.

Behaviour:
Reset (sync_reset_n low at a clk edge):
- Outputs: m_axis_tvalid=0, s_axis_tready=0 during reset and 1 on the first cycle after, m_axis_tlast=0, phase=0, num_phases=8, cfg_err=0.
- Skid buffer emptied; frame_start flag set. Applies mid-frame too; a partial frame is discarded.

Handshake:
- An input is accepted when s_axis_tvalid & s_axis_tready.
- An output transfers when m_axis_tvalid & m_axis_tready.
- m_axis_* and phase are held stable while m_axis_tvalid=1 and m_axis_tready=0.

Latency:
- 1 cycle from input acceptance to m_axis_tvalid when the output register is empty or draining.

Skid buffer:
- States are EMPTY, ONE (output register full), TWO (output plus skid full).
- s_axis_tready=1 only in EMPTY and ONE (registered next-state decode).
- EMPTY: an accepted input goes to ONE.
- ONE: accept with no transfer goes to TWO; transfer with no accept goes to EMPTY; both together stay in ONE.
- TWO: a transfer moves skid to output and goes to ONE.
- No accept is possible in TWO. No overflow and no drop under any tready pattern.

Phase sequencing (applied at the input side, on accept):
- When frame_start=1, sample cfg_num_phases.
  - Legal value: active count N := cfg value.
  - Illegal value (0, 1, or >2**PHASE_WIDTH): keep the previous N and set cfg_err.
- The first sample of a frame gets phase N-1. Each accept decrements the phase.
- The sample with phase 0 gets tlast=1; frame_start is set for the next accept.
- Changes to cfg_num_phases mid-frame are ignored until the next frame boundary.
- phase, num_phases and tlast are stored with the sample in the skid buffer, so every output word carries the tags that were valid when it was accepted.

Width rules:
- phase=N-1 is computed in NPH_WIDTH bits and truncated to PHASE_WIDTH bits; N=8 gives phase 7.

Optional Feature:
- Macro: PFB_SEQ_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - A flush pulse while mid-frame (frame_start=0) enters the PAD state. In PAD, s_axis_tready=0 and zero samples (tdata=0) are injected with the remaining descending phases down to phase 0 (tlast=1), then frame_start is set and normal operation returns.
  - A flush with frame_start=1 is ignored.
  - A flush during PAD is ignored.
  - Padding obeys the same skid rules.
- Undefined:
  - No flush port; partial frames stay pending until real samples complete them.

Test Plan:
- cfg_num_phases=8, 16 samples streamed with m_axis_tready=1 -> phases 7..0, 7..0; tlast on outputs 8 and 16; tdata unchanged; first output 1 cycle after the first accept.
- cfg_num_phases=4, changed to 8 after the 2nd sample -> phases 3,2,1,0 (tlast), then 7..0 with num_phases=8.
- m_axis_tready toggles 1,0,0,1 with a continuous input -> s_axis_tready drops the cycle after the skid fills; 32 samples in, 32 out in order; no duplicates.
- cfg_num_phases=9 at a frame start while N=4 -> cfg_err=1 and stays high; phases remain 3..0.
- Reset pulled low after 3 of 8 samples -> m_axis_tvalid=0 next cycle; the next frame starts at phase 7.
- PFB_SEQ_FLUSH_EN, N=8, flush after 5 samples -> 3 zero words with phases 2,1,0 (tlast on phase 0); s_axis_tready=0 during the pad; the next real sample gets phase 7.

Source files
------------

// File: rtl/pfb_input_sequencer_if.sv
// Stream bundle between the raw sample source, the PFB input sequencer and
// the PFB sample port. The sequencer drives the m_axis side plus its phase tags
// and consumes the s_axis side.
interface pfb_input_sequencer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int PHASE_WIDTH = 3,
  parameter int NPH_WIDTH   = 4
);
  logic                   s_axis_tvalid;
  logic [DATA_WIDTH-1:0]  s_axis_tdata;
  logic                   s_axis_tready;
  logic                   m_axis_tvalid;
  logic [DATA_WIDTH-1:0]  m_axis_tdata;
  logic                   m_axis_tlast;
  logic                   m_axis_tready;
  logic [PHASE_WIDTH-1:0] phase;
  logic [NPH_WIDTH-1:0]   num_phases;

  // Sequencer view: masters the tagged stream towards the PFB.
  modport master (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    output phase, num_phases
  );

  // Environment view: sample source and PFB sample port.
  modport slave (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    input  phase, num_phases
  );
endinterface

// File: rtl/pfb_input_sequencer.sv
// PFB input sequencer: tags each raw sample with its commutator phase
// (counting down from N-1 to 0), the active phase count N and a frame-end
// tlast on phase 0. A 2-entry skid buffer keeps s_axis_tready registered.
// Optional macro PFB_SEQ_FLUSH_EN adds a flush input that pads a partial
// frame with zero samples down to phase 0.
module pfb_input_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int PHASE_WIDTH = 3,
  parameter int NPH_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 sync_reset_n,
  input  logic [NPH_WIDTH-1:0] cfg_num_phases,
`ifdef PFB_SEQ_FLUSH_EN
  input  logic                 flush,
`endif
  output logic                 cfg_err,
  pfb_input_sequencer_if.master bus
);

  localparam logic [NPH_WIDTH-1:0] MAX_N = NPH_WIDTH'(2 ** PHASE_WIDTH);
  localparam logic [NPH_WIDTH-1:0] MIN_N = NPH_WIDTH'(2);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // A sample travels together with the tags it was given at acceptance.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [PHASE_WIDTH-1:0] phase;
    logic [NPH_WIDTH-1:0]   nph;
    logic                   last;
  } word_t;

  localparam word_t RESET_WORD = '{data: '0, phase: '0, nph: MAX_N, last: 1'b0};

  skid_state_t state_reg, state_next;
  word_t       out_word_reg, out_word_next;
  word_t       skid_word_reg, skid_word_next;
  logic        ready_reg, ready_next;

  logic                   frame_start_reg, frame_start_next;
  logic [PHASE_WIDTH-1:0] next_phase_reg, next_phase_next;
  logic [NPH_WIDTH-1:0]   n_reg, n_next;
  logic                   cfg_err_reg, cfg_err_next;

  logic                   pad_active;
  logic                   cfg_legal;
  logic [NPH_WIDTH-1:0]   in_n;
  logic [PHASE_WIDTH-1:0] in_phase;
  word_t                  in_word;
  logic                   load;
  logic                   xfer;

`ifdef PFB_SEQ_FLUSH_EN
  logic pad_reg, pad_next;
  assign pad_active = pad_reg;
`else
  assign pad_active = 1'b0;
`endif

  assign cfg_legal = (cfg_num_phases >= MIN_N) && (cfg_num_phases <= MAX_N);

  // Tag the word about to be loaded: a frame start latches a new N if legal.
  always_comb begin
    in_n     = n_reg;
    in_phase = next_phase_reg;
    if (frame_start_reg) begin
      in_n     = cfg_legal ? cfg_num_phases : n_reg;
      in_phase = PHASE_WIDTH'(in_n - NPH_WIDTH'(1));
    end
    in_word.data  = pad_active ? '0 : bus.s_axis_tdata;
    in_word.phase = in_phase;
    in_word.nph   = in_n;
    in_word.last  = (in_phase == '0);
  end

  // Padding words are injected whenever the buffer has room; real samples
  // only enter through the registered ready.
  assign load = pad_active ? (state_reg != TWO)
                           : (bus.s_axis_tvalid & ready_reg);
  assign xfer = (state_reg != EMPTY) & bus.m_axis_tready;

  // Skid buffer next-state: output register plus one overflow entry.
  always_comb begin
    state_next     = state_reg;
    out_word_next  = out_word_reg;
    skid_word_next = skid_word_reg;
    case (state_reg)
      EMPTY: begin
        if (load) begin
          out_word_next = in_word;
          state_next    = ONE;
        end
      end
      ONE: begin
        if (load && !xfer) begin
          skid_word_next = in_word;
          state_next     = TWO;
        end else if (!load && xfer) begin
          state_next = EMPTY;
        end else if (load && xfer) begin
          out_word_next = in_word;
        end
      end
      TWO: begin
        if (xfer) begin
          out_word_next = skid_word_reg;
          state_next    = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Phase sequencing and padding control, advanced on every loaded word.
  always_comb begin
    frame_start_next = frame_start_reg;
    next_phase_next  = next_phase_reg;
    n_next           = n_reg;
    cfg_err_next     = cfg_err_reg;
    if (load) begin
      frame_start_next = in_word.last;
      next_phase_next  = in_phase - PHASE_WIDTH'(1);
      n_next           = in_n;
      if (frame_start_reg && !cfg_legal) begin
        cfg_err_next = 1'b1;
      end
    end
`ifdef PFB_SEQ_FLUSH_EN
    pad_next = pad_reg;
    if (pad_reg && load && in_word.last) begin
      pad_next = 1'b0;
    end else if (flush && !pad_reg && !frame_start_reg && !(load && in_word.last)) begin
      pad_next = 1'b1;
    end
    ready_next = (state_next != TWO) && !pad_next;
`else
    ready_next = (state_next != TWO);
`endif
  end

  // State registers with synchronous active-low reset; a partial frame is dropped.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state_reg       <= EMPTY;
      out_word_reg    <= RESET_WORD;
      skid_word_reg   <= RESET_WORD;
      ready_reg       <= 1'b0;
      frame_start_reg <= 1'b1;
      next_phase_reg  <= '0;
      n_reg           <= MAX_N;
      cfg_err_reg     <= 1'b0;
`ifdef PFB_SEQ_FLUSH_EN
      pad_reg         <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      out_word_reg    <= out_word_next;
      skid_word_reg   <= skid_word_next;
      ready_reg       <= ready_next;
      frame_start_reg <= frame_start_next;
      next_phase_reg  <= next_phase_next;
      n_reg           <= n_next;
      cfg_err_reg     <= cfg_err_next;
`ifdef PFB_SEQ_FLUSH_EN
      pad_reg         <= pad_next;
`endif
    end
  end

  assign bus.s_axis_tready = ready_reg;
  assign bus.m_axis_tvalid = (state_reg != EMPTY);
  assign bus.m_axis_tdata  = out_word_reg.data;
  assign bus.m_axis_tlast  = out_word_reg.last;
  assign bus.phase         = out_word_reg.phase;
  assign bus.num_phases    = out_word_reg.nph;
  assign cfg_err           = cfg_err_reg;

endmodule

// File: tb/tb_pfb_input_sequencer.sv
// Directed bench for pfb_input_sequencer: a spec-level tagging model pushes
// expected words into a queue on every accepted input; every output transfer
// pops and compares the full tagged word.
module tb_pfb_input_sequencer;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  ph;
    logic [3:0]  n;
    logic        l;
  } exp_t;

  logic       clk = 1'b0;
  logic       sync_reset_n;
  logic [3:0] cfg_num_phases;
  logic       flush;
  logic       cfg_err;

  logic       rst_req   = 1'b0;
  logic [3:0] cfg_req   = 4'd8;
  logic       flush_req = 1'b0;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;
  int   outs   = 0;
  bit   m_fs   = 1'b1;
  int   m_n    = 8;
  int   m_ph   = 0;
  bit   m_err  = 1'b0;

  pfb_input_sequencer_if #(.DATA_WIDTH(32), .PHASE_WIDTH(3), .NPH_WIDTH(4)) bus ();

  pfb_input_sequencer #(.DATA_WIDTH(32), .PHASE_WIDTH(3), .NPH_WIDTH(4)) dut (
    .clk            (clk),
    .sync_reset_n   (sync_reset_n),
    .cfg_num_phases (cfg_num_phases),
`ifdef PFB_SEQ_FLUSH_EN
    .flush          (flush),
`endif
    .cfg_err        (cfg_err),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive at the falling edge, then judge what the next
  // rising edge will transfer and accept.
  task automatic step(input logic v, input logic [31:0] d, input logic rdy, output bit acc);
    exp_t e;
    int   ph;
    acc = 1'b0;
    @(negedge clk);
    sync_reset_n       = rst_req;
    cfg_num_phases     = cfg_req;
    flush              = flush_req;
    bus.s_axis_tvalid  = v;
    bus.s_axis_tdata   = d;
    bus.m_axis_tready  = rdy;
    #1;
    if (!rst_req) begin
      q.delete();
      m_fs  = 1'b1;
      m_n   = 8;
      m_err = 1'b0;
      return;
    end
    chk("cfg_err", {63'd0, cfg_err}, {63'd0, m_err});
    if (bus.m_axis_tvalid && rdy) begin
      if (q.size() == 0) begin
        chk("out_unexpected", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        outs++;
        $display("out data=%h phase=%0d num_phases=%0d tlast=%0d", bus.m_axis_tdata,
                 bus.phase, bus.num_phases, bus.m_axis_tlast);
        chk("out_word", {24'd0, bus.m_axis_tdata, bus.phase, bus.num_phases, bus.m_axis_tlast},
            {24'd0, e});
      end
    end
    if (v && bus.s_axis_tready) begin
      if (m_fs) begin
        if (cfg_req >= 4'd2 && cfg_req <= 4'd8) m_n = int'(cfg_req);
        else m_err = 1'b1;
        ph = m_n - 1;
      end else begin
        ph = m_ph;
      end
      q.push_back('{d: d, ph: 3'(ph), n: 4'(m_n), l: (ph == 0)});
      m_fs = (ph == 0);
      m_ph = ph - 1;
      acc  = 1'b1;
    end
`ifdef PFB_SEQ_FLUSH_EN
    if (flush_req && !m_fs) begin
      for (int p = m_ph; p >= 0; p--) begin
        q.push_back('{d: 32'd0, ph: 3'(p), n: 4'(m_n), l: (p == 0)});
      end
      m_fs = 1'b1;
    end
`endif
  endtask

  // Push n samples; toggle selects the 1,0,0,1 downstream ready pattern.
  task automatic send(input int n, input logic [31:0] base, input bit toggle, output int low_cnt);
    int  k = 0;
    int  cyc = 0;
    bit  acc;
    logic rdy;
    low_cnt = 0;
    while (k < n && cyc < 40 * n) begin
      rdy = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      step(1'b1, base + 32'(k), rdy, acc);
      if (!bus.s_axis_tready) low_cnt++;
      if (acc) k++;
      cyc++;
    end
    chk("send_count", 64'(k), 64'(n));
  endtask

  task automatic drain(input string tag);
    bit acc;
    for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, 32'd0, 1'b1, acc);
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int low;
    sync_reset_n      = 1'b0;
    cfg_num_phases    = 4'd8;
    flush             = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b0;

    // Reset values.
    rst_req = 1'b0;
    step(1'b0, 32'd0, 1'b1, acc);
    step(1'b0, 32'd0, 1'b1, acc);
    rst_req = 1'b1;
    step(1'b0, 32'd0, 1'b1, acc);
    chk("rst_tvalid", {63'd0, bus.m_axis_tvalid}, 64'd0);
    chk("rst_tready", {63'd0, bus.s_axis_tready}, 64'd0);
    chk("rst_tlast", {63'd0, bus.m_axis_tlast}, 64'd0);
    chk("rst_phase", 64'(bus.phase), 64'd0);
    chk("rst_num_phases", 64'(bus.num_phases), 64'd8);
    step(1'b0, 32'd0, 1'b1, acc);
    chk("ready_after_rst", {63'd0, bus.s_axis_tready}, 64'd1);

    // N=8, 16 samples, first output one cycle after the first accept.
    cfg_req = 4'd8;
    step(1'b1, 32'hA000_0000, 1'b1, acc);
    chk("first_accept", {63'd0, acc}, 64'd1);
    @(posedge clk);
    #1;
    chk("latency", {63'd0, bus.m_axis_tvalid}, 64'd1);
    send(15, 32'hA000_0001, 1'b0, low);
    drain("drain_n8");

    // N=4, cfg changed to 8 mid-frame.
    cfg_req = 4'd4;
    send(2, 32'hB000_0000, 1'b0, low);
    cfg_req = 4'd8;
    send(10, 32'hB000_0002, 1'b0, low);
    drain("drain_cfg_change");

    // Illegal cfg at frame start keeps N=4 and sets the sticky error.
    cfg_req = 4'd4;
    send(4, 32'hC000_0000, 1'b0, low);
    cfg_req = 4'd9;
    send(4, 32'hC000_0004, 1'b0, low);
    drain("drain_cfg_err");
    chk("cfg_err_set", {63'd0, cfg_err}, 64'd1);
    cfg_req = 4'd8;
    send(8, 32'hC000_0008, 1'b0, low);
    drain("drain_cfg_err2");
    chk("cfg_err_sticky", {63'd0, cfg_err}, 64'd1);

    // Backpressure pattern 1,0,0,1 with continuous input.
    outs = 0;
    send(32, 32'hD000_0000, 1'b1, low);
    drain("drain_backpressure");
    chk("bp_out_count", 64'(outs), 64'd32);
    chk("bp_ready_dropped", 64'(low > 0), 64'd1);

    // Reset mid-frame after 3 samples.
    send(3, 32'hE000_0000, 1'b0, low);
    rst_req = 1'b0;
    step(1'b0, 32'd0, 1'b1, acc);
    rst_req = 1'b1;
    step(1'b0, 32'd0, 1'b1, acc);
    chk("midrst_tvalid", {63'd0, bus.m_axis_tvalid}, 64'd0);
    chk("midrst_cfg_err", {63'd0, cfg_err}, 64'd0);
    send(8, 32'hE000_0010, 1'b0, low);
    drain("drain_after_rst");

`ifdef PFB_SEQ_FLUSH_EN
    // Flush after 5 samples pads phases 2,1,0 with zeros.
    send(5, 32'hF000_0000, 1'b0, low);
    flush_req = 1'b1;
    step(1'b0, 32'd0, 1'b1, acc);
    flush_req = 1'b0;
    step(1'b0, 32'd0, 1'b1, acc);
    chk("pad_ready_low", {63'd0, bus.s_axis_tready}, 64'd0);
    send(8, 32'hF000_0010, 1'b0, low);
    drain("drain_flush");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
